hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised successor to the pipeline's load-use detector. It tracks every in-flight register write in a per-register scoreboard, so it covers single-cycle ALU results, loads, and variable-latency long operations (MUL/DIV). It supports both forwarding and no-forwarding datapaths and drives the PC / IF/ID stall and ID/EX bubble controls. Sits beside the ID stage: it sees the instruction being decoded, updates its state when that instruction issues to EX, and is released by long-unit completion pulses.

## Interface
- FORWARDING, 1: 1 = EX/MEM/WB forwarding present; 0 = no forwarding, regfile is write-through (a write in WB is readable in ID the same cycle).
- NUM_REGS, 32: architectural registers; RW = $clog2(NUM_REGS); register 0 is hardwired zero and never tracked.
- MAX_LONG, 2: maximum outstanding long operations (1..7).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_id_valid  in  1  ID holds a real instruction.
- i_id_rs1, i_id_rs2  in  RW  source registers.
- i_id_uses_rs1, i_id_uses_rs2  in  1  the source is actually read.
- i_id_reg_write  in  1  the ID instruction writes i_id_rd.
- i_id_rd  in  RW  destination register.
- i_id_mem_read  in  1  the ID instruction is a load.
- i_id_long  in  1  the ID instruction goes to the long unit. Its result returns via i_long_done.
- i_flush  in  1  squash IF/ID this cycle (taken branch or jump in EX).
- i_long_done  in  1  the long unit writes i_long_rd to the regfile this cycle.
- i_long_rd  in  RW  destination of the completing long op.
- o_stall_pc, o_stall_if_id, o_bubble_id_ex  out  1  all three are the same `stall` signal.
- o_stall_cause  out  2  0 none, 1 RAW countdown, 2 long busy (RAW/WAW), 3 long unit full.
- o_busy_mask  out  NUM_REGS  bit r = register r has a nonzero countdown or a long-busy flag (debug).

## Operation
- State:
  - cnt[r], 2 bits per register (r ≥ 1): remaining stall cycles for a consumer in ID.
  - lbusy[r]: a long op to r is outstanding.
  - lcount: outstanding long ops, 0..MAX_LONG.
- Delay D loaded at issue:
  - ALU: D = FORWARDING ? 0 : 2.
  - Load: D = FORWARDING ? 1 : 2.
- A source s is checked only if its uses_rs bit is set and s ≠ 0.
- `raw`: any checked source has cnt[s] ≠ 0.
- `lhaz`: any checked source, or i_id_rd when i_id_reg_write, has lbusy set. Exception: the register equal to i_long_done/i_long_rd in the same cycle does not count (done bypass).
- `full`: i_id_long and lcount == MAX_LONG and not i_long_done.
- `stall` = i_id_valid & ~i_flush & (raw | lhaz | full).
- Cause priority when several apply: raw (1) > lhaz (2) > full (3).
- `issue` = i_id_valid & ~i_flush & ~stall.
- On issue with i_id_reg_write and i_id_rd ≠ 0:
  - Long op: set lbusy[rd]; cnt[rd] is untouched.
  - Otherwise: cnt[rd] ← D, overriding any pending decrement.
- On issue with i_id_long: lcount increments.
- Every cycle, every cnt[r] ≠ 0 not being loaded decrements by 1. This is independent of stall, because downstream stages keep moving.
- On i_long_done:
  - Clear lbusy[i_long_rd]. A set from a same-cycle issue to the same register wins.
  - lcount decrements, saturating at 0.
  - If both an issued long op and a done occur, lcount is unchanged.
- Flushed or stalled instructions never modify the scoreboard.

## Timing
- Reset (i_rst_n low at an edge): all cnt, lbusy and lcount go to 0. Reset overrides any same-cycle issue or done.
- Outputs are combinational from state and inputs, so after reset they read: stall 0, cause 0, busy_mask 0.
- Producer issues at edge c. Its consumer sits in ID during cycle c+1 and sees cnt = D:
  - It stalls D cycles and issues in cycle c+1+D.
  - Forwarding load: 1 bubble. No-forward ALU or load: 2 bubbles. Forwarding ALU: 0.
- Long RAW or WAW: the stall holds until the cycle i_long_done names the register. The consumer issues in that same cycle.
- No stall output is asserted in a cycle with i_flush or ~i_id_valid.

## Test plan
- FORWARDING=1: `lw x5`, then `add x6,x5,x1` -> stall high exactly 1 cycle, cause 1; the add issues on the 2nd ID cycle.
- FORWARDING=0: `addi x3` then `sub x4,x3,x3` -> stall 2 cycles. With FORWARDING=1 the same sequence -> 0 stalls.
- `div x7` issued; `add x8,x7,x0` held -> cause 2 until i_long_done with rd=7, and the add issues in that same cycle. WAW `addi x7` behind an outstanding `div x7` -> also stalls until done.
- MAX_LONG=2: three back-to-back long ops with no done -> the third stalls with cause 3. A done in the third op's ID cycle releases it that cycle, and lcount stays 2.
- Load to x0, or a source with uses_rs=0 -> no stall. i_flush during a pending load-use -> stall 0 and the scoreboard is unchanged.
- Reset asserted with cnt[5]=1 and lbusy[7]=1 -> next cycle busy_mask=0 and no stall on x5 or x7.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside the ID stage. It tracks short-latency
// producers with a per-register countdown and long-unit producers with busy
// flags, and generates the PC / IF/ID stall and ID/EX bubble controls.
module hazard_scoreboard #(
  parameter int FORWARDING = 1,
  parameter int NUM_REGS   = 32,
  parameter int MAX_LONG   = 2,
  localparam int RW        = $clog2(NUM_REGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_id_valid,
  input  logic [RW-1:0]       i_id_rs1,
  input  logic [RW-1:0]       i_id_rs2,
  input  logic                i_id_uses_rs1,
  input  logic                i_id_uses_rs2,
  input  logic                i_id_reg_write,
  input  logic [RW-1:0]       i_id_rd,
  input  logic                i_id_mem_read,
  input  logic                i_id_long,
  input  logic                i_flush,
  input  logic                i_long_done,
  input  logic [RW-1:0]       i_long_rd,
  output logic                o_stall_pc,
  output logic                o_stall_if_id,
  output logic                o_bubble_id_ex,
  output logic [1:0]          o_stall_cause,
  output logic [NUM_REGS-1:0] o_busy_mask
);

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_RAW  = 2'd1,
    CAUSE_LONG = 2'd2,
    CAUSE_FULL = 2'd3
  } cause_e;

  localparam logic [1:0] D_ALU  = (FORWARDING != 0) ? 2'd0 : 2'd2;
  localparam logic [1:0] D_LOAD = (FORWARDING != 0) ? 2'd1 : 2'd2;
  localparam logic [2:0] LMAX   = 3'(MAX_LONG);

  logic [1:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:0] lbusy;
  logic [NUM_REGS-1:0] lbusy_nxt;
  logic [NUM_REGS-1:0] done_mask;
  logic [NUM_REGS-1:0] lbusy_eff;
  logic [2:0]          lcount;

  logic   chk1, chk2;
  logic   raw, lhaz, full;
  logic   stall, issue;
  logic   load_en;
  logic [1:0] load_val;
  cause_e cause;

  // One-hot of the register the long unit is writing this cycle (done bypass)
  always_comb begin
    done_mask = '0;
    if (i_long_done) done_mask[i_long_rd] = 1'b1;
    lbusy_eff = lbusy & ~done_mask;
  end

  // Hazard detection, stall generation and cause priority
  always_comb begin
    chk1  = i_id_uses_rs1 && (i_id_rs1 != '0);
    chk2  = i_id_uses_rs2 && (i_id_rs2 != '0);
    raw   = (chk1 && (cnt[i_id_rs1] != 2'd0)) ||
            (chk2 && (cnt[i_id_rs2] != 2'd0));
    lhaz  = (chk1 && lbusy_eff[i_id_rs1]) ||
            (chk2 && lbusy_eff[i_id_rs2]) ||
            (i_id_reg_write && lbusy_eff[i_id_rd]);
    full  = i_id_long && (lcount == LMAX) && !i_long_done;
    stall = i_id_valid && !i_flush && (raw || lhaz || full);
    issue = i_id_valid && !i_flush && !stall;
    cause = CAUSE_NONE;
    if (stall) begin
      if (raw)       cause = CAUSE_RAW;
      else if (lhaz) cause = CAUSE_LONG;
      else           cause = CAUSE_FULL;
    end
  end

  // Next-state terms for the countdown load and long busy flags
  always_comb begin
    load_en  = issue && i_id_reg_write && !i_id_long && (i_id_rd != '0);
    load_val = i_id_mem_read ? D_LOAD : D_ALU;
    // Done clears first so a same-cycle issue to the same register wins
    lbusy_nxt = lbusy & ~done_mask;
    if (issue && i_id_reg_write && i_id_long && (i_id_rd != '0))
      lbusy_nxt[i_id_rd] = 1'b1;
    lbusy_nxt[0] = 1'b0;
  end

  // Scoreboard state: countdowns, long busy flags and outstanding long count
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      lbusy  <= '0;
      lcount <= '0;
    end else begin
      cnt[0] <= '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (load_en && (i_id_rd == RW'(r)))
          cnt[r] <= load_val;
        else if (cnt[r] != 2'd0)
          cnt[r] <= cnt[r] - 2'd1;
      end
      lbusy <= lbusy_nxt;
      if (issue && i_id_long) begin
        if (!i_long_done) lcount <= lcount + 3'd1;
      end else if (i_long_done && (lcount != '0)) begin
        lcount <= lcount - 3'd1;
      end
    end
  end

  // Debug view of every register with a pending countdown or long result
  always_comb begin
    o_busy_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      o_busy_mask[r] = (cnt[r] != 2'd0) || lbusy[r];
  end

  assign o_stall_pc     = stall;
  assign o_stall_if_id  = stall;
  assign o_bubble_id_ex = stall;
  assign o_stall_cause  = cause;

endmodule
